// File: rtl/text_buf_pkg.sv
// Shared types and helpers for the text cell buffer: sequencer states,
// the default blank code and the scroll-aware row/column to address mapping.
package text_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLEAR      = 2'd1,
        ST_SCROLL_CLR = 2'd2
    } state_t;

    localparam int DEFAULT_BLANK_CHAR = 0;

    // Logical row is offset by the scroll pointer and wrapped into the physical row range.
    function automatic int unsigned map_addr(
        input int unsigned row,
        input int unsigned col,
        input int unsigned top,
        input int unsigned rows,
        input int unsigned cols
    );
        int unsigned phys;
        phys = row + top;
        if (phys >= rows) begin
            phys = phys - rows;
        end
        return phys * cols + col;
    endfunction

endpackage

// File: rtl/text_buf_dpram.sv
// Simple dual-port RAM: one write port and one registered read-first read port,
// written so synthesis maps it onto block RAM.
module text_buf_dpram #(
    parameter int DEPTH  = 2400,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_cell_buffer.sv
// Character-cell buffer for the VGA text path with clear/scroll sequencer.
// Optional cursor overlay is built when TEXT_CELL_CURSOR_EN is defined.
module text_cell_buffer
    import text_buf_pkg::*;
#(
    parameter int COLS        = 80,
    parameter int ROWS        = 30,
    parameter int CHAR_W      = 8,
    parameter int CELL_W_LOG2 = 3,
    parameter int CELL_H_LOG2 = 4,
    parameter int DOT_W       = 10,
    parameter int LINE_W      = 9,
`ifdef TEXT_CELL_CURSOR_EN
    parameter int BLINK_LOG2  = 5,
`endif
    parameter logic [CHAR_W-1:0] BLANK_CHAR = CHAR_W'(DEFAULT_BLANK_CHAR)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(COLS)-1:0]   wr_col,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [CHAR_W-1:0]         wr_char,
    input  logic                      clear_req,
    input  logic                      scroll_req,
    output logic                      busy,
    input  logic [DOT_W-1:0]          dot_counter,
    input  logic [LINE_W-1:0]         scanline_counter,
`ifdef TEXT_CELL_CURSOR_EN
    input  logic [$clog2(COLS)-1:0]   cur_col,
    input  logic [$clog2(ROWS)-1:0]   cur_row,
    input  logic                      cur_on,
    output logic                      cursor_hit,
`endif
    output logic [CHAR_W-1:0]         char_out,
    output logic [$clog2(ROWS)-1:0]   top_row
);

    localparam int DEPTH     = ROWS * COLS;
    localparam int ADDR_W    = $clog2(DEPTH);
    localparam int RD_COL_W  = DOT_W - CELL_W_LOG2;
    localparam int RD_ROW_W  = LINE_W - CELL_H_LOG2;
    localparam int LAST_ADDR = DEPTH - 1;

    state_t            state;
    logic              ready_q;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] seq_end;

    logic [RD_COL_W-1:0] rd_col;
    logic [RD_ROW_W-1:0] rd_row;
    logic                rd_blank;
    logic [ADDR_W-1:0]   rd_addr;
    logic                blank_p1;
    logic [CHAR_W-1:0]   ram_q;

    logic                wr_in_range;
    logic                wr_fire;
    logic [ADDR_W-1:0]   wr_addr;
    logic                seq_active;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [CHAR_W-1:0]   ram_wdata;

    logic [ADDR_W-1:0]        top_base;
    logic [$clog2(ROWS)-1:0]  top_next;

    // Sub-cell dot/line bits select pixels inside the glyph, not the cell.
    logic unused_cell_lsbs;
    assign unused_cell_lsbs = ^{dot_counter[CELL_W_LOG2-1:0], scanline_counter[CELL_H_LOG2-1:0]};

    assign rd_col   = dot_counter[DOT_W-1:CELL_W_LOG2];
    assign rd_row   = scanline_counter[LINE_W-1:CELL_H_LOG2];
    assign rd_blank = (32'(rd_col) >= COLS) || (32'(rd_row) >= ROWS);
    assign rd_addr  = rd_blank ? '0
                    : ADDR_W'(map_addr(32'(rd_row), 32'(rd_col), 32'(top_row), ROWS, COLS));

    // Requests steal the write slot in the same cycle they arrive.
    assign wr_ready    = ready_q && !clear_req && !scroll_req;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign wr_addr     = ADDR_W'(map_addr(32'(wr_row), 32'(wr_col), 32'(top_row), ROWS, COLS));

    assign seq_active = (state != ST_IDLE);
    assign ram_we     = seq_active || (wr_fire && wr_in_range);
    assign ram_waddr  = seq_active ? seq_addr : wr_addr;
    assign ram_wdata  = seq_active ? BLANK_CHAR : wr_char;

    assign top_base = ADDR_W'(map_addr(32'd0, 32'd0, 32'(top_row), ROWS, COLS));
    assign top_next = (32'(top_row) == ROWS - 1) ? '0 : top_row + 1'b1;

    text_buf_dpram #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(rd_addr),
        .rdata(ram_q)
    );

    // Sequencer: CLEAR sweeps the whole array, SCROLL_CLR blanks the row just scrolled off the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CLEAR;
            seq_addr <= '0;
            seq_end  <= ADDR_W'(LAST_ADDR);
            top_row  <= '0;
            ready_q  <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state    <= ST_CLEAR;
                        seq_addr <= '0;
                        seq_end  <= ADDR_W'(LAST_ADDR);
                        top_row  <= '0;
                        ready_q  <= 1'b0;
                        busy     <= 1'b1;
                    end else if (scroll_req) begin
                        state    <= ST_SCROLL_CLR;
                        seq_addr <= top_base;
                        seq_end  <= top_base + ADDR_W'(COLS - 1);
                        top_row  <= top_next;
                        ready_q  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_CLEAR, ST_SCROLL_CLR: begin
                    if (seq_addr == seq_end) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        seq_addr <= seq_addr + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: address registered inside the RAM, blank flag alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_p1 <= 1'b1;
        end else begin
            blank_p1 <= rd_blank;
        end
    end

    // Stage 2: substitute the blank code outside the text area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_out <= BLANK_CHAR;
        end else begin
            char_out <= blank_p1 ? BLANK_CHAR : ram_q;
        end
    end

`ifdef TEXT_CELL_CURSOR_EN
    logic [LINE_W-1:0]     scan_prev;
    logic [BLINK_LOG2-1:0] blink_cnt;
    logic                  phase;
    logic                  frame_tick;
    logic                  cell_match;
    logic                  last_lines;
    logic                  hit_p1;

    assign frame_tick = (scan_prev != '0) && (scanline_counter == '0);
    assign cell_match = (32'(rd_col) == 32'(cur_col)) && (32'(rd_row) == 32'(cur_row));
    assign last_lines = &scanline_counter[CELL_H_LOG2-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_prev  <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            hit_p1     <= 1'b0;
            cursor_hit <= 1'b0;
        end else begin
            scan_prev <= scanline_counter;
            if (frame_tick) begin
                blink_cnt <= blink_cnt + 1'b1;
                if (&blink_cnt) begin
                    phase <= ~phase;
                end
            end
            hit_p1     <= cur_on && phase && !rd_blank && cell_match && last_lines;
            cursor_hit <= hit_p1;
        end
    end
`endif

endmodule
